// File: rtl/stream_merge_4to1.sv
// stream_merge_4to1: four valid/ready input streams merged onto one
// registered valid/ready output with per-beat round-robin arbitration.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   ctrl_wr_en/_data    write strobe and value for the input enable mask
//   in_data_N           input stream data (N = 0..3)
//   in_valid_N          input N presents a beat
//   in_ready_N          input N beat accepted this cycle (combinational)
//   out_data/out_src    registered merged beat and its source index
//   out_valid/out_ready output handshake
//   enable_mask         current enable mask (registered)
module stream_merge_4to1 #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ctrl_wr_en,
   input  logic [3:0]            ctrl_wr_data,
   input  logic [DATA_WIDTH-1:0] in_data_0,
   input  logic [DATA_WIDTH-1:0] in_data_1,
   input  logic [DATA_WIDTH-1:0] in_data_2,
   input  logic [DATA_WIDTH-1:0] in_data_3,
   input  logic                  in_valid_0,
   input  logic                  in_valid_1,
   input  logic                  in_valid_2,
   input  logic                  in_valid_3,
   output logic                  in_ready_0,
   output logic                  in_ready_1,
   output logic                  in_ready_2,
   output logic                  in_ready_3,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [1:0]            out_src,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [3:0]            enable_mask
);

   logic [3:0]            req;
   logic [3:0]            grant;
   logic [1:0]            gidx;
   logic                  found;
   logic [1:0]            rr_ptr;
   logic                  load;
   logic                  xfer;
   logic [DATA_WIDTH-1:0] sel_data;
   logic [1:0]            idx;

   assign load = !out_valid | out_ready;

   assign req = {in_valid_3, in_valid_2, in_valid_1, in_valid_0}
              & enable_mask;

   // First requester at or after rr_ptr, wrapping modulo 4.
   always_comb begin
      grant = 4'b0000;
      gidx  = 2'd0;
      found = 1'b0;
      idx   = 2'd0;
      for (int k = 0; k < 4; k++) begin
         idx = rr_ptr + 2'(k);
         if (!found && req[idx]) begin
            found       = 1'b1;
            gidx        = idx;
            grant[idx]  = 1'b1;
         end
      end
   end

   assign xfer = found & load & !rst;

   assign in_ready_0 = load & grant[0] & !rst;
   assign in_ready_1 = load & grant[1] & !rst;
   assign in_ready_2 = load & grant[2] & !rst;
   assign in_ready_3 = load & grant[3] & !rst;

   always_comb begin
      sel_data = in_data_0;
      unique case (gidx)
         2'd0: sel_data = in_data_0;
         2'd1: sel_data = in_data_1;
         2'd2: sel_data = in_data_2;
         2'd3: sel_data = in_data_3;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid   <= 1'b0;
         out_data    <= '0;
         out_src     <= 2'd0;
         rr_ptr      <= 2'd0;
         enable_mask <= 4'b1111;
      end else begin
         if (ctrl_wr_en)
            enable_mask <= ctrl_wr_data;
         if (xfer) begin
            out_data  <= sel_data;
            out_src   <= gidx;
            out_valid <= 1'b1;
            rr_ptr    <= gidx + 2'd1;
         end else if (out_ready) begin
            // Draining with nothing new to load: empty the register,
            // leaving data and source as they were.
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_stream_merge_4to1.sv
// tb_stream_merge_4to1: directed, table-driven bench for stream_merge_4to1.
// Each record is one cycle: inputs, expected ready, expected outputs after the edge.
module tb_stream_merge_4to1;

   logic        clk = 1'b0;
   logic        rst;
   logic        ctrl_wr_en;
   logic [3:0]  ctrl_wr_data;
   logic [31:0] in_data_0, in_data_1, in_data_2, in_data_3;
   logic        in_valid_0, in_valid_1, in_valid_2, in_valid_3;
   logic        in_ready_0, in_ready_1, in_ready_2, in_ready_3;
   logic [31:0] out_data;
   logic [1:0]  out_src;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  enable_mask;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   stream_merge_4to1 #(.DATA_WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .ctrl_wr_en(ctrl_wr_en), .ctrl_wr_data(ctrl_wr_data),
      .in_data_0(in_data_0), .in_data_1(in_data_1),
      .in_data_2(in_data_2), .in_data_3(in_data_3),
      .in_valid_0(in_valid_0), .in_valid_1(in_valid_1),
      .in_valid_2(in_valid_2), .in_valid_3(in_valid_3),
      .in_ready_0(in_ready_0), .in_ready_1(in_ready_1),
      .in_ready_2(in_ready_2), .in_ready_3(in_ready_3),
      .out_data(out_data), .out_src(out_src),
      .out_valid(out_valid), .out_ready(out_ready),
      .enable_mask(enable_mask)
   );

   typedef struct {
      logic        rst;
      logic        wr;
      logic [3:0]  wd;
      logic [3:0]  vld;
      logic        ordy;
      logic [3:0]  erdy;
      logic        ev;
      logic [1:0]  esrc;
      logic [31:0] edata;
      logic [3:0]  emask;
   } vec_t;

   localparam int NV = 30;
   vec_t tbl [NV];

   function automatic vec_t mk(input logic r, input logic w,
                               input logic [3:0] wd, input logic [3:0] v,
                               input logic o, input logic [3:0] er,
                               input logic ev, input logic [1:0] es,
                               input logic [31:0] ed, input logic [3:0] em);
      vec_t x;
      x.rst = r; x.wr = w; x.wd = wd; x.vld = v; x.ordy = o;
      x.erdy = er; x.ev = ev; x.esrc = es; x.edata = ed; x.emask = em;
      return x;
   endfunction

   // Input i carries base + i*0x100.
   task automatic drive_data(input logic [31:0] base);
      in_data_0 = base;
      in_data_1 = base + 32'h100;
      in_data_2 = base + 32'h200;
      in_data_3 = base + 32'h300;
   endtask

   task automatic check(input string name, input int t,
                        input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s step=%0d got=%h expected=%h", name, t, got, exp);
      end
   endtask

   function automatic logic [3:0] rdy_vec();
      return {in_ready_3, in_ready_2, in_ready_1, in_ready_0};
   endfunction

   initial begin
      //              rst wr wd      vld     ordy erdy    ev es  edata        emask
      tbl[0]  = mk(1, 0, 4'h0, 4'b0000, 0, 4'b0000, 0, 0, 32'h000, 4'hF);
      tbl[1]  = mk(1, 0, 4'h0, 4'b1111, 0, 4'b0000, 0, 0, 32'h000, 4'hF);
      tbl[2]  = mk(0, 0, 4'h0, 4'b0100, 1, 4'b0100, 1, 2, 32'h202, 4'hF);
      tbl[3]  = mk(0, 0, 4'h0, 4'b0100, 1, 4'b0100, 1, 2, 32'h203, 4'hF);
      tbl[4]  = mk(0, 0, 4'h0, 4'b0100, 1, 4'b0100, 1, 2, 32'h204, 4'hF);
      tbl[5]  = mk(0, 0, 4'h0, 4'b0000, 1, 4'b0000, 0, 2, 32'h204, 4'hF);
      tbl[6]  = mk(1, 0, 4'h0, 4'b0000, 1, 4'b0000, 0, 0, 32'h000, 4'hF);
      tbl[7]  = mk(0, 0, 4'h0, 4'b1111, 1, 4'b0001, 1, 0, 32'h007, 4'hF);
      tbl[8]  = mk(0, 0, 4'h0, 4'b1111, 1, 4'b0010, 1, 1, 32'h108, 4'hF);
      tbl[9]  = mk(0, 0, 4'h0, 4'b1111, 1, 4'b0100, 1, 2, 32'h209, 4'hF);
      tbl[10] = mk(0, 0, 4'h0, 4'b1111, 1, 4'b1000, 1, 3, 32'h30A, 4'hF);
      tbl[11] = mk(0, 0, 4'h0, 4'b1111, 1, 4'b0001, 1, 0, 32'h00B, 4'hF);
      tbl[12] = mk(0, 0, 4'h0, 4'b1111, 1, 4'b0010, 1, 1, 32'h10C, 4'hF);
      tbl[13] = mk(0, 0, 4'h0, 4'b1111, 0, 4'b0000, 1, 1, 32'h10C, 4'hF);
      tbl[14] = mk(0, 0, 4'h0, 4'b1111, 0, 4'b0000, 1, 1, 32'h10C, 4'hF);
      tbl[15] = mk(0, 0, 4'h0, 4'b1111, 0, 4'b0000, 1, 1, 32'h10C, 4'hF);
      tbl[16] = mk(0, 0, 4'h0, 4'b1111, 1, 4'b0100, 1, 2, 32'h210, 4'hF);
      tbl[17] = mk(0, 1, 4'h5, 4'b1111, 1, 4'b1000, 1, 3, 32'h311, 4'h5);
      tbl[18] = mk(0, 0, 4'h0, 4'b1111, 1, 4'b0001, 1, 0, 32'h012, 4'h5);
      tbl[19] = mk(0, 0, 4'h0, 4'b1111, 1, 4'b0100, 1, 2, 32'h213, 4'h5);
      tbl[20] = mk(0, 0, 4'h0, 4'b1111, 1, 4'b0001, 1, 0, 32'h014, 4'h5);
      tbl[21] = mk(0, 1, 4'h0, 4'b1111, 0, 4'b0000, 1, 0, 32'h014, 4'h0);
      tbl[22] = mk(0, 0, 4'h0, 4'b1111, 0, 4'b0000, 1, 0, 32'h014, 4'h0);
      tbl[23] = mk(0, 0, 4'h0, 4'b1111, 1, 4'b0000, 0, 0, 32'h014, 4'h0);
      tbl[24] = mk(0, 0, 4'h0, 4'b1111, 1, 4'b0000, 0, 0, 32'h014, 4'h0);
      tbl[25] = mk(0, 1, 4'hF, 4'b1111, 1, 4'b0000, 0, 0, 32'h014, 4'hF);
      tbl[26] = mk(0, 1, 4'h3, 4'b1111, 0, 4'b0010, 1, 1, 32'h11A, 4'h3);
      tbl[27] = mk(1, 0, 4'h0, 4'b1111, 1, 4'b0000, 0, 0, 32'h000, 4'hF);
      tbl[28] = mk(0, 0, 4'h0, 4'b1111, 1, 4'b0001, 1, 0, 32'h01C, 4'hF);
      tbl[29] = mk(0, 0, 4'h0, 4'b0000, 1, 4'b0000, 0, 0, 32'h01C, 4'hF);

      rst = 1'b1; ctrl_wr_en = 1'b0; ctrl_wr_data = 4'h0; out_ready = 1'b0;
      {in_valid_3, in_valid_2, in_valid_1, in_valid_0} = 4'b0000;
      drive_data(32'h0);
      @(posedge clk); #1;

      for (int t = 0; t < NV; t++) begin
         rst          = tbl[t].rst;
         ctrl_wr_en   = tbl[t].wr;
         ctrl_wr_data = tbl[t].wd;
         out_ready    = tbl[t].ordy;
         {in_valid_3, in_valid_2, in_valid_1, in_valid_0} = tbl[t].vld;
         drive_data(32'(t));
         #1;
         check("in_ready", t, 32'(rdy_vec()), 32'(tbl[t].erdy));
         @(posedge clk); #1;
         check("out_valid", t, 32'(out_valid), 32'(tbl[t].ev));
         check("out_src", t, 32'(out_src), 32'(tbl[t].esrc));
         check("out_data", t, out_data, tbl[t].edata);
         check("enable_mask", t, 32'(enable_mask), 32'(tbl[t].emask));
      end

      // Stalled beat must not follow input data changes; after release the
      // next granted beat (input 2, pointer at 2) appears exactly once.
      rst = 1'b0; ctrl_wr_en = 1'b0; out_ready = 1'b0;
      {in_valid_3, in_valid_2, in_valid_1, in_valid_0} = 4'b1111;
      drive_data(32'h55);
      #1;
      check("seq_ready_load", 100, 32'(rdy_vec()), 32'h2);
      @(posedge clk); #1;
      check("seq_data_load", 100, out_data, 32'h155);
      drive_data(32'hDEAD0000);
      for (int n = 0; n < 3; n++) begin
         #1;
         check("seq_ready_stall", 101 + n, 32'(rdy_vec()), 32'h0);
         @(posedge clk); #1;
         check("seq_data_stall", 101 + n, out_data, 32'h155);
         check("seq_valid_stall", 101 + n, 32'(out_valid), 32'h1);
      end
      out_ready = 1'b1;
      {in_valid_3, in_valid_2, in_valid_1, in_valid_0} = 4'b0100;
      #1;
      check("seq_ready_release", 104, 32'(rdy_vec()), 32'h4);
      @(posedge clk); #1;
      check("seq_data_release", 104, out_data, 32'hDEAD0200);
      check("seq_src_release", 104, 32'(out_src), 32'h2);
      {in_valid_3, in_valid_2, in_valid_1, in_valid_0} = 4'b0000;
      @(posedge clk); #1;
      check("seq_valid_drain", 105, 32'(out_valid), 32'h0);
      check("seq_data_drain", 105, out_data, 32'hDEAD0200);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
